// File: rtl/vga_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_seq_pkg
// Description : Shared types and default widths for the VGA draw sequencer.
//               seq_state_t  - sequencer FSM encoding
//               SCR_*        - default coordinate/colour widths (160x120, 3-bit)
// Revision    : 1.0 - initial release
// ============================================================================
package vga_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEEK = 3'd1,
        RUN  = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } seq_state_t;

    localparam int SCR_X_W   = 8;
    localparam int SCR_Y_W   = 7;
    localparam int SCR_COL_W = 3;

endpackage
`default_nettype wire

// File: rtl/vga_client_mux.sv
`default_nettype none
// ============================================================================
// Module      : vga_client_mux
// Description : Combinational N-way pixel select. Forwards the x/y/colour/plot
//               of client idx when valid is high, otherwise drives all zero.
// Ports       : idx, valid                          - selection and gate
//               client_x/y/colour/plot              - packed client buses
//               vga_x/vga_y/vga_colour/vga_plot     - selected pixel
// Revision    : 1.0 - initial release
// ============================================================================
module vga_client_mux
    import vga_seq_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int X_W       = SCR_X_W,
    parameter int Y_W       = SCR_Y_W,
    parameter int COL_W     = SCR_COL_W,
    parameter int IDX_W     = $clog2(N_CLIENTS)
) (
    input  logic [IDX_W-1:0]           idx,
    input  logic                       valid,
    input  logic [N_CLIENTS*X_W-1:0]   client_x,
    input  logic [N_CLIENTS*Y_W-1:0]   client_y,
    input  logic [N_CLIENTS*COL_W-1:0] client_colour,
    input  logic [N_CLIENTS-1:0]       client_plot,
    output logic [X_W-1:0]             vga_x,
    output logic [Y_W-1:0]             vga_y,
    output logic [COL_W-1:0]           vga_colour,
    output logic                       vga_plot
);

    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (valid && (idx == IDX_W'(i))) begin
                vga_x      = client_x[i*X_W +: X_W];
                vga_y      = client_y[i*Y_W +: Y_W];
                vga_colour = client_colour[i*COL_W +: COL_W];
                vga_plot   = client_plot[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vga_draw_sequencer
// Description : Runs up to N_CLIENTS drawing clients one at a time through a
//               start/done handshake and muxes the running client's pixel
//               stream onto the single vga_adapter port. Supports a per-client
//               enable mask, loop mode, abort and auto-run after reset.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               go, abort, loop, en_mask   - sequence control
//               client_start/done          - per-client handshake
//               client_x/y/colour/plot     - packed client pixel buses
//               vga_x/y/colour/plot        - muxed pixel to the adapter
//               busy, seq_done, cur_idx    - status
// Revision    : 1.0 - initial release
// ============================================================================
module vga_draw_sequencer
    import vga_seq_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int X_W       = SCR_X_W,
    parameter int Y_W       = SCR_Y_W,
    parameter int COL_W     = SCR_COL_W,
    parameter int AUTO_RUN  = 1,
    localparam int IDX_W    = $clog2(N_CLIENTS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       go,
    input  logic                       abort,
    input  logic                       loop,
    input  logic [N_CLIENTS-1:0]       en_mask,
    output logic [N_CLIENTS-1:0]       client_start,
    input  logic [N_CLIENTS-1:0]       client_done,
    input  logic [N_CLIENTS*X_W-1:0]   client_x,
    input  logic [N_CLIENTS*Y_W-1:0]   client_y,
    input  logic [N_CLIENTS*COL_W-1:0] client_colour,
    input  logic [N_CLIENTS-1:0]       client_plot,
    output logic [X_W-1:0]             vga_x,
    output logic [Y_W-1:0]             vga_y,
    output logic [COL_W-1:0]           vga_colour,
    output logic                       vga_plot,
    output logic                       busy,
    output logic                       seq_done,
    output logic [IDX_W-1:0]           cur_idx
);

    localparam logic [N_CLIENTS-1:0] c_START_LSB = N_CLIENTS'(1);
    localparam logic [IDX_W-1:0]     c_LAST_IDX  = IDX_W'(N_CLIENTS - 1);

    seq_state_t           r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [N_CLIENTS-1:0] r_mask;
    logic                 r_loop;
    logic [N_CLIENTS-1:0] r_start;
    logic                 r_busy;
    logic                 r_seq_done;
    // Set by reset; the first edge after release consumes it as an implicit go.
    logic                 r_auto_pend;

    logic                 w_go;
    logic [N_CLIENTS-1:0] w_go_mask;
    logic                 w_go_loop;
    logic                 w_found;
    logic [IDX_W-1:0]     w_found_idx;

    assign w_go      = go | r_auto_pend;
    assign w_go_mask = r_auto_pend ? '1   : en_mask;
    assign w_go_loop = r_auto_pend ? 1'b0 : loop;

    // Lowest enabled client at or above the current index. Scanning downwards
    // lets the last hit (the lowest index) win.
    always_comb begin
        w_found     = 1'b0;
        w_found_idx = '0;
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            if (r_mask[i] && (IDX_W'(i) >= r_idx)) begin
                w_found     = 1'b1;
                w_found_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_mask      <= '0;
            r_loop      <= 1'b0;
            r_start     <= '0;
            r_busy      <= 1'b0;
            r_seq_done  <= 1'b0;
            r_auto_pend <= (AUTO_RUN != 0);
        end else begin
            r_auto_pend <= 1'b0;
            if (abort) begin
                r_state    <= IDLE;
                r_start    <= '0;
                r_busy     <= 1'b0;
                r_seq_done <= 1'b0;
            end else begin
                case (r_state)
                    IDLE, DONE: begin
                        if (w_go) begin
                            r_mask     <= w_go_mask;
                            r_loop     <= w_go_loop;
                            r_idx      <= '0;
                            r_state    <= SEEK;
                            r_busy     <= 1'b1;
                            r_seq_done <= 1'b0;
                        end
                    end
                    SEEK: begin
                        if (w_found) begin
                            r_state <= RUN;
                            r_idx   <= w_found_idx;
                            r_start <= c_START_LSB << w_found_idx;
                        end else if (r_loop && (r_mask != '0)) begin
                            r_idx <= '0;
                        end else begin
                            r_state    <= DONE;
                            r_busy     <= 1'b0;
                            r_seq_done <= 1'b1;
                        end
                    end
                    RUN: begin
                        // Only the running client's done counts.
                        if (client_done[r_idx]) begin
                            r_state <= GAP;
                            r_start <= '0;
                        end
                    end
                    GAP: begin
                        if (r_idx == c_LAST_IDX) begin
                            if (r_loop) begin
                                r_idx   <= '0;
                                r_state <= SEEK;
                            end else begin
                                r_state    <= DONE;
                                r_busy     <= 1'b0;
                                r_seq_done <= 1'b1;
                            end
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= SEEK;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_start <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign client_start = r_start;
    assign busy         = r_busy;
    assign seq_done     = r_seq_done;
    assign cur_idx      = r_idx;

    // Pixel path is purely combinational so clients see no added latency.
    vga_client_mux #(
        .N_CLIENTS (N_CLIENTS),
        .X_W       (X_W),
        .Y_W       (Y_W),
        .COL_W     (COL_W),
        .IDX_W     (IDX_W)
    ) u_mux (
        .idx           (r_idx),
        .valid         (r_state == RUN),
        .client_x      (client_x),
        .client_y      (client_y),
        .client_colour (client_colour),
        .client_plot   (client_plot),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .vga_colour    (vga_colour),
        .vga_plot      (vga_plot)
    );

endmodule
`default_nettype wire

// File: tb/tb_vga_draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_draw_sequencer
// Description : Self-checking bench for vga_draw_sequencer (N=4, AUTO_RUN=1).
//               Behavioural clients raise done 5 cycles after start; expected
//               start order is queued when each sequence is launched and popped
//               as client starts rise. The muxed pixel is checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_draw_sequencer;

    localparam int N  = 4;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;

    logic          clk;
    logic          rst_n;
    logic          go;
    logic          abort;
    logic          loop;
    logic [N-1:0]  en_mask;
    logic [N-1:0]  client_start;
    logic [N-1:0]  client_done;
    logic [N*XW-1:0] client_x;
    logic [N*YW-1:0] client_y;
    logic [N*CW-1:0] client_colour;
    logic [N-1:0]  client_plot;
    logic [XW-1:0] vga_x;
    logic [YW-1:0] vga_y;
    logic [CW-1:0] vga_colour;
    logic          vga_plot;
    logic          busy;
    logic          seq_done;
    logic [1:0]    cur_idx;

    logic [N-1:0]  force_done;
    logic [N-1:0]  c_done_r;
    logic [7:0]    c_cnt [N];

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    bit chk_gap  = 1'b0;
    int ncyc     = 0;
    int last_fall = -1;
    logic [N-1:0] prev_start = '0;

    vga_draw_sequencer #(
        .N_CLIENTS (N),
        .X_W       (XW),
        .Y_W       (YW),
        .COL_W     (CW),
        .AUTO_RUN  (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .go            (go),
        .abort         (abort),
        .loop          (loop),
        .en_mask       (en_mask),
        .client_start  (client_start),
        .client_done   (client_done),
        .client_x      (client_x),
        .client_y      (client_y),
        .client_colour (client_colour),
        .client_plot   (client_plot),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .vga_colour    (vga_colour),
        .vga_plot      (vga_plot),
        .busy          (busy),
        .seq_done      (seq_done),
        .cur_idx       (cur_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural clients: count while started, raise done after 5 cycles,
    // drop done once start is removed. They share the sequencer's reset.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                c_cnt[i]    <= 8'd0;
                c_done_r[i] <= 1'b0;
            end else if (!client_start[i]) begin
                c_cnt[i]    <= 8'd0;
                c_done_r[i] <= 1'b0;
            end else begin
                c_cnt[i] <= c_cnt[i] + 8'd1;
                if (c_cnt[i] == 8'd4) c_done_r[i] <= 1'b1;
            end
        end
    end

    always_comb begin
        client_x      = '0;
        client_y      = '0;
        client_colour = '0;
        client_plot   = '0;
        for (int i = 0; i < N; i++) begin
            client_x[i*XW +: XW]      = 8'(i * 40) + c_cnt[i];
            client_y[i*YW +: YW]      = 7'(i * 30) + c_cnt[i][6:0];
            client_colour[i*CW +: CW] = 3'(i + 1);
            client_plot[i]            = client_start[i] & c_cnt[i][0];
        end
    end

    assign client_done = c_done_r | force_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: start order scoreboard, one-hot start, pixel mux every cycle.
    always @(negedge clk) begin : mon
        logic [N-1:0]  rise;
        logic [N-1:0]  fall;
        int            k;
        int            act;
        logic [XW-1:0] ex;
        logic [YW-1:0] ey;
        logic [CW-1:0] ec;
        logic          ep;
        ncyc++;
        rise = client_start & ~prev_start;
        fall = prev_start & ~client_start;
        if (fall != '0) last_fall = ncyc;
        if (rise != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_start", 32'(client_start), 32'd0);
            end else begin
                k = exp_q.pop_front();
                check("start_order", 32'(client_start), 32'(1) << k);
                check("cur_idx_on_start", 32'(cur_idx), 32'(k));
                if (chk_gap && last_fall >= 0)
                    check("done_to_next_start", 32'(ncyc - last_fall), 32'd2);
            end
        end
        check("start_at_most_one", 32'(($countones(client_start) <= 1) ? 1 : 0), 32'd1);
        act = -1;
        for (int i = 0; i < N; i++) if (client_start[i]) act = i;
        ex = '0; ey = '0; ec = '0; ep = 1'b0;
        if (act >= 0) begin
            ex = 8'(act * 40) + c_cnt[act];
            ey = 7'(act * 30) + c_cnt[act][6:0];
            ec = 3'(act + 1);
            ep = c_cnt[act][0];
        end
        check("vga_x", 32'(vga_x), 32'(ex));
        check("vga_y", 32'(vga_y), 32'(ey));
        check("vga_colour", 32'(vga_colour), 32'(ec));
        check("vga_plot", 32'(vga_plot), 32'(ep));
        prev_start = client_start;
    end

    task automatic wait_seq_done(input int budget);
        int k = 0;
        while (seq_done !== 1'b1 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check("seq_done_reached", 32'(seq_done), 32'd1);
    endtask

    task automatic wait_q_empty(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check("expected_starts_seen", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_any_start(input int budget);
        int k = 0;
        while (client_start == '0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check("some_start_seen", 32'((client_start != '0) ? 1 : 0), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; go = 1'b0; abort = 1'b0; loop = 1'b0;
        en_mask = '0; force_done = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_start", 32'(client_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_seq_done", 32'(seq_done), 32'd0);
        check("rst_cur_idx", 32'(cur_idx), 32'd0);

        // Auto-run after release: 0,1,2,3 in turn.
        for (int i = 0; i < N; i++) exp_q.push_back(i);
        chk_gap = 1'b1;
        last_fall = -1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("auto_seek_busy", 32'(busy), 32'd1);
        check("auto_no_start_yet", 32'(client_start), 32'd0);
        @(negedge clk); #1;
        check("auto_first_start", 32'(client_start), 32'd1);
        wait_seq_done(200);
        check("auto_all_started", 32'(exp_q.size()), 32'd0);
        check("auto_done_not_busy", 32'(busy), 32'd0);
        chk_gap = 1'b0;

        // Sparse mask 1010; a go pulse while busy must be ignored.
        exp_q.push_back(1);
        exp_q.push_back(3);
        en_mask = 4'b1010; loop = 1'b0; go = 1'b1;
        @(negedge clk); #1;
        go = 1'b0; en_mask = '0;
        check("go_clears_seq_done", 32'(seq_done), 32'd0);
        wait_any_start(20);
        go = 1'b1; en_mask = '1; loop = 1'b1;
        @(negedge clk); #1;
        go = 1'b0; en_mask = '0; loop = 1'b0;
        wait_seq_done(200);
        check("mask1010_starts", 32'(exp_q.size()), 32'd0);

        // Empty mask reaches DONE two edges after go, with and without loop.
        for (int lp = 0; lp < 2; lp++) begin
            en_mask = '0; loop = lp[0]; go = 1'b1;
            @(negedge clk); #1;
            go = 1'b0; loop = 1'b0;
            check("mask0_seek_busy", 32'(busy), 32'd1);
            check("mask0_not_done_yet", 32'(seq_done), 32'd0);
            @(negedge clk); #1;
            check("mask0_done", 32'(seq_done), 32'd1);
            check("mask0_not_busy", 32'(busy), 32'd0);
            check("mask0_no_start", 32'(client_start), 32'd0);
        end

        // Done from a non-running client is ignored.
        exp_q.push_back(0);
        exp_q.push_back(2);
        en_mask = 4'b0101; go = 1'b1;
        @(negedge clk); #1;
        go = 1'b0; en_mask = '0;
        wait_any_start(20);
        force_done = 4'b0100;
        repeat (3) @(negedge clk);
        #1;
        check("stray_done_start_held", 32'(client_start), 32'd1);
        check("stray_done_cur_idx", 32'(cur_idx), 32'd0);
        check("stray_done_colour", 32'(vga_colour), 32'd1);
        force_done = '0;
        wait_seq_done(200);
        check("mask0101_starts", 32'(exp_q.size()), 32'd0);

        // Loop over 0011, abort together with go during client 1's second run.
        exp_q.push_back(0); exp_q.push_back(1);
        exp_q.push_back(0); exp_q.push_back(1);
        en_mask = 4'b0011; loop = 1'b1; go = 1'b1;
        @(negedge clk); #1;
        go = 1'b0; loop = 1'b0; en_mask = '0;
        wait_q_empty(200);
        check("loop_second_client1", 32'(client_start), 32'd2);
        abort = 1'b1; go = 1'b1; en_mask = '1;
        @(negedge clk); #1;
        check("abort_start_low", 32'(client_start), 32'd0);
        check("abort_not_busy", 32'(busy), 32'd0);
        check("abort_no_seq_done", 32'(seq_done), 32'd0);
        @(negedge clk); #1;
        check("abort_beats_go_idle", 32'(busy), 32'd0);
        abort = 1'b0; go = 1'b0; en_mask = '0;
        repeat (10) @(negedge clk);
        #1;
        check("idle_after_abort", 32'(busy), 32'd0);
        check("idle_no_seq_done", 32'(seq_done), 32'd0);

        // Reset in the middle of a run, then auto-run from client 0 again.
        exp_q.push_back(0);
        exp_q.push_back(1);
        en_mask = '1; go = 1'b1;
        @(negedge clk); #1;
        go = 1'b0; en_mask = '0;
        wait_q_empty(100);
        check("pre_reset_client1", 32'(client_start), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_start", 32'(client_start), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_plot", 32'(vga_plot), 32'd0);
        check("async_rst_cur_idx", 32'(cur_idx), 32'd0);
        @(negedge clk); #1;
        for (int i = 0; i < N; i++) exp_q.push_back(i);
        rst_n = 1'b1;
        wait_seq_done(200);
        check("rerun_all_started", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
